fifo_8i_wr_arbiter: RTL and testbench
=====================================

Name: fifo_8I_wr_arbiter

Overview:
- Write-side scheduler that shares one multi-lane-write FIFO (up to LANES words pushed per cycle, push-count interface) between NREQ requesters.
- Each requester sends packets of one or more beats. A beat is up to LANES words plus a word count and a last flag.
- Round-robin arbitration at packet granularity. The winner is locked until its last beat, so packets never interleave inside the FIFO.
- Sits directly in front of the FIFO write port: drives push/wdata and consumes the FIFO's full flag.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 32, data word width
- LANES, 8, words per beat; equals the FIFO's write lanes
- CNTW, 4, width of word-count fields; must hold LANES, i.e. clog2(LANES)+1

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous abort of arbitration state
- req_valid  in  NREQ  beat valid per requester
- req_last  in  NREQ  beat is last of packet
- req_cnt  in  NREQ x CNTW  words in beat (0..LANES)
- req_data  in  NREQ x LANES x WIDTH  beat words, lane 0 first
- req_ready  out  NREQ  beat accepted this cycle (valid & ready)
- fifo_full  in  1  FIFO cannot take a full beat
- fifo_push  out  CNTW  word count pushed this cycle
- fifo_wdata  out  LANES x WIDTH  words to FIFO
- grant_id  out  clog2(NREQ)  requester of most recently accepted beat
- busy  out  1  arbiter locked mid-packet
- cnt_err  out  1  sticky: accepted beat had req_cnt > LANES

Behaviour:
- Reset values:
  - state IDLE, rr_ptr 0, owner 0
  - grant_id 0, busy 0, cnt_err 0
  - req_ready 0, fifo_push 0, fifo_wdata 0
- Datapath is combinational, zero latency. A beat accepted in cycle N is pushed to the FIFO in cycle N.
- Handshake:
  - A beat is accepted when req_valid[i] and req_ready[i] are both high.
  - At most one req_ready bit is high per cycle.
  - req_ready never depends on the same requester's req_valid being low, i.e. a ready bit is asserted only together with valid.
- IDLE state:
  - winner = first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
  - If a winner exists and fifo_full=0: req_ready[winner]=1 and the beat is pushed.
  - If the accepted beat has last=1: stay IDLE, rr_ptr <= winner+1 (mod NREQ).
  - If the accepted beat has last=0: go to LOCK, owner <= winner.
  - If fifo_full=1: no acceptance, no state or rr_ptr change. The winner is recomputed next cycle.
- LOCK state:
  - Only owner is eligible: req_ready[owner] = req_valid[owner] & !fifo_full.
  - If the owner's valid is low, the cycle is an idle bubble with push 0. Other requesters stay blocked.
  - An accepted beat with last=1 returns to IDLE and sets rr_ptr <= owner+1.
- busy = (state == LOCK).
- grant_id updates on every acceptance.
- fifo_push = accepted req_cnt clamped to LANES; 0 when nothing is accepted.
- fifo_wdata:
  - lanes 0..push-1 carry the winner's data; lanes >= push are driven 0.
  - all lanes are 0 when idle.
- req_cnt = 0 with valid: a legal empty beat. It handshakes (may carry last) with push 0.
- req_cnt > LANES: the beat is accepted, push is clamped to LANES, and cnt_err is set. cnt_err is sticky until flush or reset.
- Wrap-around: rr_ptr = NREQ-1 advances to 0. Winner NREQ-1 followed by requester 0 is legal.
- flush:
  - In the flush cycle all req_ready=0 and push=0.
  - Next state IDLE, rr_ptr 0, cnt_err 0. grant_id is held.
  - flush overrides any simultaneous valid or last.
- Reset mid-packet: reverts to the reset values. The partial packet already pushed stays in the FIFO; flushing the FIFO is the system's job.

Optional Feature:
- Macro FIFO_ARB_STATS_EN.
- Defined:
  - Adds output pkt_count, NREQ x 16.
  - Per-requester packet counter increments on acceptance of a last beat and saturates at 0xFFFF.
  - Cleared by reset and by flush.
- Undefined: the port and counters are absent. All other behaviour is identical.

Decomposition:
- Package fifo_arb_pkg holds:
  - state enum {IDLE, LOCK}
  - default LANES/WIDTH constants
  - count-width helper function
  - beat struct type {last, cnt, data}
- Sub-module rr_picker:
  - combinational NREQ-wide round-robin priority selector
  - inputs: request vector, pointer
  - outputs: one-hot grant, index, any
  - reused in LOCK as a masked single request.

Test Plan:
- Single packet: req1 sends 3 beats, cnt 8/8/5, last on beat 3 -> fifo_push 8,8,5 on consecutive cycles; busy=1 after beat 1, 0 after beat 3; rr_ptr=2; grant_id=1.
- Contention: all 4 requesters send 1-beat packets continuously from reset -> grant order 0,1,2,3,0; every fifo_push equals req_cnt.
- Lock hold: req0 two-beat packet with 2-cycle valid gap between beats while req2 valid -> req2 not ready until req0's last beat is accepted, then granted the next cycle.
- Backpressure: fifo_full=1 for 3 cycles mid-LOCK -> no ready, push 0, state held; the beat is accepted the cycle full drops.
- Boundary counts: cnt=0 last=1 -> handshake with push 0, rr advances; cnt=12 -> push 8, cnt_err=1 until flush.
- Flush mid-packet: flush in LOCK with owner valid -> ready 0, push 0 that cycle; next cycle IDLE, rr_ptr 0, requester 0 wins if valid. With FIFO_ARB_STATS_EN, pkt_count is cleared.

Source files
------------

// File: rtl/fifo_8i_wr_arbiter_pkg.sv
// Shared types and constants for the multi-lane FIFO write arbiter.
// Optional statistics are enabled by defining FIFO_ARB_STATS_EN.
package fifo_arb_pkg;

    localparam int DEF_LANES = 8;
    localparam int DEF_WIDTH = 32;

    // A word-count field must be able to hold the value LANES itself.
    function automatic int cnt_width(input int lanes);
        return $clog2(lanes) + 1;
    endfunction

    localparam int DEF_CNTW = cnt_width(DEF_LANES);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic                                  last;
        logic [DEF_CNTW-1:0]                   cnt;
        logic [DEF_LANES-1:0][DEF_WIDTH-1:0]   data;
    } beat_t;

endpackage

// File: rtl/fifo_8i_wr_arbiter_if.sv
// Requester-side beat bus: master is the set of requesters, slave is the arbiter.
interface fifo_8i_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = DEF_WIDTH,
    parameter int LANES = DEF_LANES,
    parameter int CNTW  = cnt_width(LANES)
);
    logic [NREQ-1:0]                         req_valid;
    logic [NREQ-1:0]                         req_last;
    logic [NREQ-1:0][CNTW-1:0]               req_cnt;
    logic [NREQ-1:0][LANES-1:0][WIDTH-1:0]   req_data;
    logic [NREQ-1:0]                         req_ready;

    modport master (
        output req_valid, req_last, req_cnt, req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_last, req_cnt, req_data,
        output req_ready
    );
endinterface

// File: rtl/fifo_8i_wr_arbiter_rr_picker.sv
// Combinational round-robin selector: first set request at or after ptr, modulo N.
module rr_picker #(
    parameter int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);
    logic [IW-1:0] cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int k = 0; k < N; k++) begin
            cand = IW'((int'(ptr) + k) % N);
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end
endmodule

// File: rtl/fifo_8i_wr_arbiter.sv
// Packet-granular round-robin write arbiter in front of a multi-lane FIFO.
// Define FIFO_ARB_STATS_EN to add per-requester saturating packet counters.
module fifo_8i_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = DEF_WIDTH,
    parameter int LANES = DEF_LANES,
    parameter int CNTW  = cnt_width(LANES),
    localparam int IW   = $clog2(NREQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    fifo_8i_wr_arbiter_if.slave           req,
    input  logic                          fifo_full,
    output logic [CNTW-1:0]               fifo_push,
    output logic [LANES-1:0][WIDTH-1:0]   fifo_wdata,
    output logic [IW-1:0]                 grant_id,
    output logic                          busy,
    output logic                          cnt_err
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [NREQ-1:0][15:0]         pkt_count
`endif
);
    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_LOCK = LOCK;

    function automatic logic [CNTW-1:0] clamp_cnt(input logic [CNTW-1:0] c);
        return (c > CNTW'(LANES)) ? CNTW'(LANES) : c;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        return (i == IW'(NREQ - 1)) ? '0 : i + 1'b1;
    endfunction

    logic [0:0]      state;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   owner;
    logic [NREQ-1:0] pick_req;
    logic [NREQ-1:0] pick_gnt;
    logic [IW-1:0]   pick_ptr;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic            accept;
    logic            sel_last;
    logic            cnt_over;
    logic [CNTW-1:0] sel_cnt;

    // While locked, the picker sees only the owner's request, so one picker serves both states.
    always_comb begin
        pick_req = req.req_valid;
        pick_ptr = rr_ptr;
        if (state == ST_LOCK) begin
            pick_req = req.req_valid & (NREQ'(1) << owner);
            pick_ptr = owner;
        end
    end

    rr_picker #(.N(NREQ)) u_pick (
        .req (pick_req),
        .ptr (pick_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign accept        = rst_n & pick_any & ~fifo_full & ~flush;
    assign req.req_ready = accept ? pick_gnt : '0;
    assign sel_cnt       = req.req_cnt[pick_idx];
    assign sel_last      = req.req_last[pick_idx];
    assign cnt_over      = sel_cnt > CNTW'(LANES);
    assign fifo_push     = accept ? clamp_cnt(sel_cnt) : '0;
    assign busy          = (state == ST_LOCK);

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            fifo_wdata[l] = (accept && (CNTW'(l) < fifo_push)) ? req.req_data[pick_idx][l] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            grant_id <= '0;
            cnt_err  <= 1'b0;
        end else if (flush) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            cnt_err  <= 1'b0;
        end else if (accept) begin
            grant_id <= pick_idx;
            if (cnt_over) cnt_err <= 1'b1;
            if (sel_last) begin
                state  <= ST_IDLE;
                rr_ptr <= next_idx(pick_idx);
            end else begin
                state  <= ST_LOCK;
                owner  <= pick_idx;
            end
        end
    end

`ifdef FIFO_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_count <= '0;
        end else if (flush) begin
            pkt_count <= '0;
        end else if (accept && sel_last) begin
            pkt_count[pick_idx] <= sat_inc(pkt_count[pick_idx]);
        end
    end
`endif
endmodule

// File: tb/tb_fifo_8i_wr_arbiter.sv
// Directed bench for fifo_8i_wr_arbiter (NREQ=4, WIDTH=32, LANES=8, CNTW=4).
module tb_fifo_8i_wr_arbiter;
    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              fifo_full;
    logic [3:0]        fifo_push;
    logic [7:0][31:0]  fifo_wdata;
    logic [1:0]        grant_id;
    logic              busy;
    logic              cnt_err;
`ifdef FIFO_ARB_STATS_EN
    logic [3:0][15:0]  pkt_count;
`endif

    int checks = 0;
    int errors = 0;

    fifo_8i_wr_arbiter_if #(.NREQ(4), .WIDTH(32), .LANES(8), .CNTW(4)) rif ();

    fifo_8i_wr_arbiter #(.NREQ(4), .WIDTH(32), .LANES(8), .CNTW(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .req        (rif),
        .fifo_full  (fifo_full),
        .fifo_push  (fifo_push),
        .fifo_wdata (fifo_wdata),
        .grant_id   (grant_id),
        .busy       (busy),
        .cnt_err    (cnt_err)
`ifdef FIFO_ARB_STATS_EN
        ,
        .pkt_count  (pkt_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ew(input int i, input int l);
        return 32'hA000_0000 | 32'(i * 256 + l);
    endfunction

    task automatic clr();
        rif.req_valid = '0;
        rif.req_last  = '0;
        rif.req_cnt   = '0;
        rif.req_data  = '0;
    endtask

    task automatic beat(input int i, input logic lst, input int cnt);
        rif.req_valid[i] = 1'b1;
        rif.req_last[i]  = lst;
        rif.req_cnt[i]   = 4'(cnt);
        for (int l = 0; l < 8; l++) rif.req_data[i][l] = ew(i, l);
    endtask

    task automatic do_reset();
        clr();
        flush     = 1'b0;
        fifo_full = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) beat(i, 1'b1, 5);
        #1;
        checks++; if (rif.req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready got %b want 0000", rif.req_ready); end
        checks++; if (fifo_push !== 4'd0) begin errors++; $display("FAIL rst_push got %0d want 0", fifo_push); end
        checks++; if (fifo_wdata !== '0) begin errors++; $display("FAIL rst_wdata got %0h want 0", fifo_wdata); end
        @(negedge clk);
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL rst_grant got %0d want 0", grant_id); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++; if (cnt_err !== 1'b0) begin errors++; $display("FAIL rst_cnt_err got %b want 0", cnt_err); end
`ifdef FIFO_ARB_STATS_EN
        checks++; if (pkt_count !== '0) begin errors++; $display("FAIL rst_pkt_count got %0h want 0", pkt_count); end
`endif
        clr();
        rst_n = 1'b1;
    endtask

    task automatic test_single_packet();
        @(negedge clk);
        beat(1, 1'b0, 8);
        #1;
        checks++; if (rif.req_ready !== 4'b0010) begin errors++; $display("FAIL sp_ready1 got %b want 0010", rif.req_ready); end
        checks++; if (fifo_push !== 4'd8) begin errors++; $display("FAIL sp_push1 got %0d want 8", fifo_push); end
        checks++; if (fifo_wdata[7] !== ew(1, 7)) begin errors++; $display("FAIL sp_wdata1 got %0h want %0h", fifo_wdata[7], ew(1, 7)); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sp_busy0 got %b want 0", busy); end
        @(negedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sp_busy1 got %b want 1", busy); end
        checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL sp_grant1 got %0d want 1", grant_id); end
        checks++; if (fifo_push !== 4'd8) begin errors++; $display("FAIL sp_push2 got %0d want 8", fifo_push); end
        @(negedge clk);
        beat(1, 1'b1, 5);
        #1;
        checks++; if (fifo_push !== 4'd5) begin errors++; $display("FAIL sp_push3 got %0d want 5", fifo_push); end
        checks++; if (fifo_wdata[4] !== ew(1, 4)) begin errors++; $display("FAIL sp_wdata3_l4 got %0h want %0h", fifo_wdata[4], ew(1, 4)); end
        checks++; if (fifo_wdata[5] !== 32'd0) begin errors++; $display("FAIL sp_wdata3_l5 got %0h want 0", fifo_wdata[5]); end
        @(negedge clk);
        clr();
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sp_busy_end got %b want 0", busy); end
        checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL sp_grant_end got %0d want 1", grant_id); end
        checks++; if (fifo_push !== 4'd0) begin errors++; $display("FAIL sp_push_idle got %0d want 0", fifo_push); end
        checks++; if (fifo_wdata !== '0) begin errors++; $display("FAIL sp_wdata_idle got %0h want 0", fifo_wdata); end
        // Pointer now sits at 2, so requester 2 beats requester 0.
        beat(0, 1'b1, 1);
        beat(2, 1'b1, 1);
        #1;
        checks++; if (rif.req_ready !== 4'b0100) begin errors++; $display("FAIL sp_rr_ptr got %b want 0100", rif.req_ready); end
        @(negedge clk);
        clr();
    endtask

    task automatic test_contention();
        logic [3:0] exp_rdy;
        do_reset();
        for (int i = 0; i < 4; i++) beat(i, 1'b1, i + 1);
        for (int n = 0; n < 5; n++) begin
            exp_rdy = 4'(1 << (n % 4));
            #1;
            checks++; if (rif.req_ready !== exp_rdy) begin errors++; $display("FAIL ct_ready%0d got %b want %b", n, rif.req_ready, exp_rdy); end
            checks++; if (fifo_push !== 4'((n % 4) + 1)) begin errors++; $display("FAIL ct_push%0d got %0d want %0d", n, fifo_push, (n % 4) + 1); end
            checks++; if (fifo_wdata[0] !== ew(n % 4, 0)) begin errors++; $display("FAIL ct_wdata%0d got %0h want %0h", n, fifo_wdata[0], ew(n % 4, 0)); end
            @(negedge clk);
            checks++; if (grant_id !== 2'(n % 4)) begin errors++; $display("FAIL ct_grant%0d got %0d want %0d", n, grant_id, n % 4); end
        end
        clr();
    endtask

    task automatic test_lock_hold();
        do_reset();
        beat(0, 1'b0, 3);
        beat(2, 1'b1, 2);
        #1;
        checks++; if (rif.req_ready !== 4'b0001) begin errors++; $display("FAIL lh_first got %b want 0001", rif.req_ready); end
        checks++; if (fifo_push !== 4'd3) begin errors++; $display("FAIL lh_push1 got %0d want 3", fifo_push); end
        @(negedge clk);
        rif.req_valid[0] = 1'b0;
        for (int g = 0; g < 2; g++) begin
            #1;
            checks++; if (rif.req_ready !== 4'b0000) begin errors++; $display("FAIL lh_gap%0d got %b want 0000", g, rif.req_ready); end
            checks++; if (fifo_push !== 4'd0) begin errors++; $display("FAIL lh_gap_push%0d got %0d want 0", g, fifo_push); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL lh_gap_busy%0d got %b want 1", g, busy); end
            @(negedge clk);
        end
        beat(0, 1'b1, 4);
        #1;
        checks++; if (rif.req_ready !== 4'b0001) begin errors++; $display("FAIL lh_last got %b want 0001", rif.req_ready); end
        checks++; if (fifo_push !== 4'd4) begin errors++; $display("FAIL lh_push2 got %0d want 4", fifo_push); end
        @(negedge clk);
        rif.req_valid[0] = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lh_busy_end got %b want 0", busy); end
        checks++; if (rif.req_ready !== 4'b0100) begin errors++; $display("FAIL lh_req2 got %b want 0100", rif.req_ready); end
        @(negedge clk);
        checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL lh_grant2 got %0d want 2", grant_id); end
        clr();
    endtask

    task automatic test_backpressure();
        do_reset();
        fifo_full = 1'b1;
        beat(3, 1'b0, 8);
        #1;
        checks++; if (rif.req_ready !== 4'b0000) begin errors++; $display("FAIL bp_idle_full got %b want 0000", rif.req_ready); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_idle_busy got %b want 0", busy); end
        fifo_full = 1'b0;
        #1;
        checks++; if (rif.req_ready !== 4'b1000) begin errors++; $display("FAIL bp_start got %b want 1000", rif.req_ready); end
        @(negedge clk);
        beat(3, 1'b1, 6);
        fifo_full = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (rif.req_ready !== 4'b0000) begin errors++; $display("FAIL bp_full_ready%0d got %b want 0000", c, rif.req_ready); end
            checks++; if (fifo_push !== 4'd0) begin errors++; $display("FAIL bp_full_push%0d got %0d want 0", c, fifo_push); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_full_busy%0d got %b want 1", c, busy); end
            @(negedge clk);
        end
        fifo_full = 1'b0;
        #1;
        checks++; if (rif.req_ready !== 4'b1000) begin errors++; $display("FAIL bp_release got %b want 1000", rif.req_ready); end
        checks++; if (fifo_push !== 4'd6) begin errors++; $display("FAIL bp_push got %0d want 6", fifo_push); end
        checks++; if (fifo_wdata[5] !== ew(3, 5)) begin errors++; $display("FAIL bp_wdata_l5 got %0h want %0h", fifo_wdata[5], ew(3, 5)); end
        checks++; if (fifo_wdata[6] !== 32'd0) begin errors++; $display("FAIL bp_wdata_l6 got %0h want 0", fifo_wdata[6]); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_busy_end got %b want 0", busy); end
        clr();
        // Pointer wrapped from 3 to 0.
        beat(0, 1'b1, 2);
        beat(3, 1'b1, 2);
        #1;
        checks++; if (rif.req_ready !== 4'b0001) begin errors++; $display("FAIL bp_wrap got %b want 0001", rif.req_ready); end
        @(negedge clk);
        clr();
    endtask

    task automatic test_boundary();
        do_reset();
        beat(2, 1'b1, 0);
        #1;
        checks++; if (rif.req_ready !== 4'b0100) begin errors++; $display("FAIL bd_empty_ready got %b want 0100", rif.req_ready); end
        checks++; if (fifo_push !== 4'd0) begin errors++; $display("FAIL bd_empty_push got %0d want 0", fifo_push); end
        checks++; if (fifo_wdata !== '0) begin errors++; $display("FAIL bd_empty_wdata got %0h want 0", fifo_wdata); end
        @(negedge clk);
        checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL bd_empty_grant got %0d want 2", grant_id); end
        clr();
        beat(2, 1'b1, 3);
        beat(3, 1'b1, 12);
        #1;
        checks++; if (rif.req_ready !== 4'b1000) begin errors++; $display("FAIL bd_over_ready got %b want 1000", rif.req_ready); end
        checks++; if (fifo_push !== 4'd8) begin errors++; $display("FAIL bd_over_push got %0d want 8", fifo_push); end
        checks++; if (fifo_wdata[7] !== ew(3, 7)) begin errors++; $display("FAIL bd_over_wdata got %0h want %0h", fifo_wdata[7], ew(3, 7)); end
        checks++; if (cnt_err !== 1'b0) begin errors++; $display("FAIL bd_err_pre got %b want 0", cnt_err); end
        @(negedge clk);
        checks++; if (cnt_err !== 1'b1) begin errors++; $display("FAIL bd_err_set got %b want 1", cnt_err); end
        clr();
        beat(0, 1'b1, 1);
        @(negedge clk);
        checks++; if (cnt_err !== 1'b1) begin errors++; $display("FAIL bd_err_sticky got %b want 1", cnt_err); end
        clr();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++; if (cnt_err !== 1'b0) begin errors++; $display("FAIL bd_err_flush got %b want 0", cnt_err); end
    endtask

    task automatic test_flush();
        do_reset();
`ifdef FIFO_ARB_STATS_EN
        beat(2, 1'b1, 1);
        @(negedge clk);
        checks++; if (pkt_count[2] !== 16'd1) begin errors++; $display("FAIL fl_pkt2 got %0d want 1", pkt_count[2]); end
        clr();
`endif
        beat(1, 1'b0, 12);
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fl_locked got %b want 1", busy); end
        checks++; if (cnt_err !== 1'b1) begin errors++; $display("FAIL fl_err_pre got %b want 1", cnt_err); end
        flush = 1'b1;
        beat(1, 1'b1, 4);
        beat(0, 1'b1, 4);
        #1;
        checks++; if (rif.req_ready !== 4'b0000) begin errors++; $display("FAIL fl_ready got %b want 0000", rif.req_ready); end
        checks++; if (fifo_push !== 4'd0) begin errors++; $display("FAIL fl_push got %0d want 0", fifo_push); end
        checks++; if (fifo_wdata !== '0) begin errors++; $display("FAIL fl_wdata got %0h want 0", fifo_wdata); end
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fl_busy got %b want 0", busy); end
        checks++; if (cnt_err !== 1'b0) begin errors++; $display("FAIL fl_err got %b want 0", cnt_err); end
        checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL fl_grant_held got %0d want 1", grant_id); end
`ifdef FIFO_ARB_STATS_EN
        checks++; if (pkt_count !== '0) begin errors++; $display("FAIL fl_pkt_clr got %0h want 0", pkt_count); end
`endif
        checks++; if (rif.req_ready !== 4'b0001) begin errors++; $display("FAIL fl_req0 got %b want 0001", rif.req_ready); end
        @(negedge clk);
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL fl_grant0 got %0d want 0", grant_id); end
        clr();
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        fifo_full = 1'b0;
        clr();
        test_reset();
        test_single_packet();
        test_contention();
        test_lock_hold();
        test_backpressure();
        test_boundary();
        test_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
